// File: rtl/vend_dispense_scheduler.sv
// Vending transaction controller: coin credit, multi-item pricing, serialised dispense and change payout.
// Latency: coin->credit 1 cycle, buy->first disp_req_o 2 cycles, final done->change_valid_o 2 cycles.
// Backpressure: one dispenser req/done handshake at a time, per-item timeout refund; optional VEND_STOCK_EN adds restock_i and stock counters.
module vend_dispense_scheduler #(
  parameter int PRICE_COLD    = 20,
  parameter int PRICE_DAIRY   = 10,
  parameter int PRICE_BISC    = 15,
  parameter int PRICE_REDBULL = 40,
  parameter int PRICE_CHOC    = 25,
  parameter int DISP_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid_i,
  input  logic [8:0] coin_value_i,
  input  logic [4:0] sel_i,
  input  logic       buy_i,
  input  logic       cancel_i,
  output logic       disp_req_o,
  output logic [2:0] disp_item_o,
  input  logic       disp_done_i,
  output logic       change_valid_o,
  output logic [8:0] change_o,
  output logic [8:0] credit_o,
  output logic       insufficient_o,
  output logic       coin_reject_o,
  output logic       busy_o
`ifdef VEND_STOCK_EN
  ,
  input  logic       restock_i
`endif
);

  localparam int CW = (DISP_TIMEOUT < 2) ? 1 : $clog2(DISP_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_GAP, S_CHANGE
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    credit_q, credit_d;
  logic [4:0]    pending_q, pending_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          insuf_q, insuf_d;
  logic          rej_q, rej_d;

  logic [10:0]   total;
  logic [2:0]    item;
  logic [4:0]    item_mask;
  logic          coin_legal;
  logic [9:0]    coin_sum;
  logic          stock_out;

  function automatic logic [8:0] price_of(input logic [2:0] idx);
    case (idx)
      3'd0:    price_of = 9'(PRICE_COLD);
      3'd1:    price_of = 9'(PRICE_DAIRY);
      3'd2:    price_of = 9'(PRICE_BISC);
      3'd3:    price_of = 9'(PRICE_REDBULL);
      3'd4:    price_of = 9'(PRICE_CHOC);
      default: price_of = 9'd0;
    endcase
  endfunction

  // Price the pending mask and pick its lowest set bit as the item to serve next.
  always_comb begin
    total = 11'd0;
    item  = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pending_q[i]) begin
        total = total + 11'(price_of(3'(i)));
        item  = 3'(i);
      end
    end
    item_mask = 5'd1 << item;
  end

  assign coin_legal = (coin_value_i == 9'd5)  || (coin_value_i == 9'd10) ||
                      (coin_value_i == 9'd20) || (coin_value_i == 9'd50) ||
                      (coin_value_i == 9'd100);
  // Summed one bit wider so an overflowing coin is refused instead of wrapping credit.
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_value_i};

`ifdef VEND_STOCK_EN
  logic [4:0][3:0] stock_q;
  logic [4:0]      stock_empty;

  // Flag items whose stock counter has run dry.
  always_comb begin
    stock_empty = 5'd0;
    for (int i = 0; i < 5; i++) begin
      stock_empty[i] = (stock_q[i] == 4'd0);
    end
  end

  assign stock_out = |(pending_q & stock_empty);

  // Restock refills every counter and beats a same-cycle decrement; timed-out items keep their count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stock_q <= {5{4'd15}};
    end else if (restock_i) begin
      stock_q <= {5{4'd15}};
    end else if ((state_q == S_WAIT) && disp_done_i) begin
      stock_q[item] <= stock_q[item] - 4'd1;
    end
  end
`else
  assign stock_out = 1'b0;
`endif

  // Transaction sequencing: credit bookkeeping, dispense serialisation and one-cycle status pulses.
  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    insuf_d   = 1'b0;
    rej_d     = coin_valid_i;
    case (state_q)
      S_IDLE: begin
        if (coin_valid_i && coin_legal && (coin_sum <= 10'd511)) begin
          credit_d = coin_sum[8:0];
          rej_d    = 1'b0;
        end
        // Cancel always suppresses a simultaneous buy, even with nothing to refund.
        if (cancel_i) begin
          if (credit_q != 9'd0) state_d = S_CHANGE;
        end else if (buy_i) begin
          pending_d = sel_i;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (pending_q == 5'd0) begin
          state_d = S_IDLE;
        end else if ((total > {2'b00, credit_q}) || stock_out) begin
          insuf_d   = 1'b1;
          pending_d = 5'd0;
          state_d   = S_IDLE;
        end else begin
          credit_d = credit_q - total[8:0];
          cnt_d    = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (disp_done_i) begin
          pending_d = pending_q & ~item_mask;
          state_d   = S_GAP;
        end else if (cnt_q == CW'(DISP_TIMEOUT - 1)) begin
          credit_d  = credit_q + price_of(item);
          pending_d = pending_q & ~item_mask;
          state_d   = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (pending_q != 5'd0) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_CHANGE;
        end
      end
      S_CHANGE: begin
        credit_d = 9'd0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      credit_q  <= 9'd0;
      pending_q <= 5'd0;
      cnt_q     <= '0;
      insuf_q   <= 1'b0;
      rej_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      insuf_q   <= insuf_d;
      rej_q     <= rej_d;
    end
  end

  assign disp_req_o     = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign disp_item_o    = disp_req_o ? item : 3'd0;
  assign change_valid_o = (state_q == S_CHANGE);
  assign change_o       = change_valid_o ? credit_q : 9'd0;
  assign credit_o       = credit_q;
  assign insufficient_o = insuf_q;
  assign coin_reject_o  = rej_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule
